// File: rtl/sub_ctrl_pkg.sv
// Shared types and constants for the nibble-serial subtract sequencer.
package sub_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index counter width; a single bit is kept even for two passes.
  function automatic int idx_width(input int nibbles);
    return (nibbles <= 2) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/sub4_slice.sv
// Combinational 4-bit borrow-lookahead subtractor: d = x - y - bin.
module sub4_slice (
  output logic [3:0] d,
  output logic       bout,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       bin
);

  logic [3:0] g, p;
  logic [4:0] b;

  // g: bit generates a borrow (0-1); p: bit passes an incoming borrow (x==y).
  assign g = ~x & y;
  assign p = ~(x ^ y);

  assign b[0] = bin;
  assign b[1] = g[0] | (p[0] & bin);
  assign b[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
  assign b[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & bin);
  assign b[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & bin);

  assign d    = x ^ y ^ b[3:0];
  assign bout = b[4];

endmodule

// File: rtl/nibble_serial_sub_ctrl.sv
// Sequences one shared 4-bit subtractor slice over WIDTH/4 passes, LSB nibble first.
module nibble_serial_sub_ctrl
  import sub_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IW      = idx_width(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_e                           state_q;
  logic [IW-1:0]                    idx_q;
  logic                             borrow_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] xr_q, yr_q, acc_q, acc_d;
  logic [WIDTH-1:0]                 d_q;
  logic                             busy_q, done_q, bout_q, zero_q, ovf_q;

  logic [NIBBLE_W-1:0] s_d;
  logic                s_bout;

  sub4_slice u_slice (
    .d    (s_d),
    .bout (s_bout),
    .x    (xr_q[idx_q]),
    .y    (yr_q[idx_q]),
    .bin  (borrow_q)
  );

  // Accumulator with the current pass's nibble merged in, so the commit edge
  // can publish the complete result without waiting another cycle.
  always_comb begin
    acc_d        = acc_q;
    acc_d[idx_q] = s_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      xr_q     <= '0;
      yr_q     <= '0;
      acc_q    <= '0;
      d_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state_q <= IDLE;
          if (start) begin
            xr_q     <= x;
            yr_q     <= y;
            borrow_q <= bin;
            idx_q    <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          borrow_q <= s_bout;
          if (idx_q == LAST) begin
            d_q     <= acc_d;
            bout_q  <= s_bout;
            zero_q  <= (acc_d == '0);
            ovf_q   <= (xr_q[NIBBLES-1][NIBBLE_W-1] != yr_q[NIBBLES-1][NIBBLE_W-1])
                    && (acc_d[NIBBLES-1][NIBBLE_W-1] != xr_q[NIBBLES-1][NIBBLE_W-1]);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// Directed plus randomized checks of the nibble-serial subtractor against an arithmetic model.
module tb_nibble_serial_sub_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] x = '0, y = '0;
  logic        bin = 1'b0;
  logic        busy, done, bout, zero, ovf;
  logic [15:0] d;

  int total = 0;
  int bad = 0;
  int done_seen = 0;

  nibble_serial_sub_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .bin(bin),
    .busy(busy), .done(done), .d(d), .bout(bout), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 17-bit arithmetic; bit 16 of the wrapped difference is the borrow.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic c,
                       output logic [15:0] ed, output logic eb, output logic ez,
                       output logic eo);
    logic [16:0] diff;
    diff = {1'b0, a} - {1'b0, b} - {16'd0, c};
    ed = diff[15:0];
    eb = (int'(a) < int'(b) + int'(c));
    ez = (ed == 16'd0);
    eo = (a[15] != b[15]) && (ed[15] != a[15]);
  endtask

  // Launch one operation; afterwards the inputs are scrambled to prove capture.
  task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic c);
    @(negedge clk);
    start = 1'b1; x = a; y = b; bin = c;
    @(negedge clk);
    start = 1'b0; x = 16'($urandom); y = 16'($urandom); bin = 1'($urandom);
  endtask

  // Called at the first negedge after acceptance; busy is already counted there.
  task automatic wait_done(output int busy_cyc, output bit ok);
    busy_cyc = 0;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin ok = 1'b1; break; end
      if (busy) busy_cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c);
    logic [15:0] ed; logic eb, ez, eo;
    int bc; bit ok;
    model(a, b, c, ed, eb, ez, eo);
    launch(a, b, c);
    wait_done(bc, ok);
    chk({tag, "_done"}, 32'(ok), 32'd1);
    if (ok) begin
      chk({tag, "_busycyc"}, 32'(bc), 32'd4);
      chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
      chk({tag, "_d"}, 32'(d), 32'(ed));
      chk({tag, "_bout"}, 32'(bout), 32'(eb));
      chk({tag, "_zero"}, 32'(zero), 32'(ez));
      chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(done), 32'd0);
      chk({tag, "_hold_d"}, 32'(d), 32'(ed));
    end
  endtask

  initial begin
    logic [15:0] ed; logic eb, ez, eo;
    logic [15:0] qa[$], qb[$]; logic qc[$];
    int bc, prev_cyc, cyc, n0;
    bit ok;

    // Reset, then idle.
    repeat (2) @(negedge clk);
    chk("rst_outs", {21'd0, busy, done, bout, zero, ovf, 6'd0}, 32'd0);
    chk("rst_d", 32'(d), 32'd0);
    rst_n = 1'b1;
    n0 = done_seen;
    repeat (10) @(negedge clk);
    chk("idle_no_done", 32'(done_seen - n0), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // Directed cases.
    run_op("basic", 16'h1234, 16'h0123, 1'b0);
    run_op("borrow", 16'h0005, 16'h000D, 1'b0);
    run_op("zz_bin", 16'h0000, 16'h0000, 1'b1);
    run_op("eq_zero", 16'hC0DE, 16'hC0DE, 1'b0);
    run_op("ovf", 16'h8000, 16'h0001, 1'b0);
    run_op("ovf_neg", 16'h7FFF, 16'hFFFF, 1'b0);

    // Start during RUN is ignored.
    n0 = done_seen;
    launch(16'h1234, 16'h0123, 1'b0);
    @(negedge clk);
    start = 1'b1; x = 16'h0001; y = 16'h0001; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done(bc, ok);
    chk("ign_done", 32'(ok), 32'd1);
    chk("ign_d", 32'(d), 32'h1111);
    repeat (8) @(negedge clk);
    chk("ign_one_done", 32'(done_seen - n0), 32'd1);

    // Start held high: new operands presented while DONE is showing.
    qa.delete(); qb.delete(); qc.delete();
    @(negedge clk);
    start = 1'b1;
    x = 16'($urandom); y = 16'($urandom); bin = 1'($urandom);
    qa.push_back(x); qb.push_back(y); qc.push_back(bin);
    prev_cyc = -1; cyc = 0;
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk); cyc++;
        if (done) begin ok = 1'b1; break; end
      end
      chk("b2b_done", 32'(ok), 32'd1);
      if (!ok) break;
      model(qa.pop_front(), qb.pop_front(), qc.pop_front(), ed, eb, ez, eo);
      chk("b2b_d", 32'(d), 32'(ed));
      chk("b2b_bout", 32'(bout), 32'(eb));
      if (prev_cyc >= 0) chk("b2b_period", 32'(cyc - prev_cyc), 32'd5);
      prev_cyc = cyc;
      x = 16'($urandom); y = 16'($urandom); bin = 1'($urandom);
      qa.push_back(x); qb.push_back(y); qc.push_back(bin);
    end
    start = 1'b0;
    repeat (8) @(negedge clk);

    // Reset during the third RUN cycle.
    launch(16'h1234, 16'h0123, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n0 = done_seen;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_d", 32'(d), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_no_done", 32'(done_seen - n0), 32'd0);
    run_op("after_rst", 16'h00FF, 16'h000F, 1'b0);

    // Randomized operations, with corner-biased operands mixed in.
    for (int k = 0; k < 20; k++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = (k % 5 == 0) ? a : 16'($urandom);
      if (k % 7 == 3) a = 16'h0000;
      run_op("rand", a, b, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_sub_ctrl.md
Name: nibble_serial_sub_ctrl

Overview:
- Sequencer that performs a WIDTH-bit subtraction D = X - Y - Bin by driving one shared 4-bit borrow subtractor slice for NIBBLES consecutive cycles.
- Nibbles are processed LSB first, and the borrow is registered between passes.
- Sits between a requester (start/done handshake) and the 4-bit subtractor datapath, trading latency for area.
- Also produces zero and signed-overflow flags.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4, derived local constant: number of slice passes. Not overridable.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled on rising clk edge.
- x  input  WIDTH  minuend; captured on accepted start.
- y  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while a subtraction is in progress (RUN state).
- done  output  1  one-cycle pulse when the result becomes valid.
- d  output  WIDTH  difference; holds until the next accepted start completes.
- bout  output  1  final borrow-out (1 means X < Y + Bin, unsigned).
- zero  output  1  high when d == 0.
- ovf  output  1  signed overflow: (x[MSB] != y[MSB]) && (d[MSB] != x[MSB]).

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; nibble index = 0; borrow register = 0; operand registers = 0.
  - Outputs: busy = 0, done = 0, d = 0, bout = 0, zero = 0, ovf = 0.
  - Reset asserted mid-RUN aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy = 0, done = 0.
  - start = 1 → capture x, y, bin into internal registers; index = 0; go to RUN.
- RUN:
  - busy = 1.
  - Each edge: the slice computes nibble[index] = xr[4i+3:4i] - yr[4i+3:4i] - borrow. The 4-bit result is written into the d-accumulator at that nibble, and borrow is updated with the slice borrow-out.
  - index < NIBBLES-1 → index+1, stay in RUN.
  - index == NIBBLES-1 → commit d, bout, zero and ovf to the output registers; go to DONE.
  - start is ignored while in RUN; the operand registers are not disturbed.
- DONE:
  - Lasts exactly one cycle; done = 1, busy = 0.
  - start = 1 in DONE is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Output update rules:
  - d, bout, zero and ovf are updated only at the commit edge. They are never partially updated and remain stable through IDLE and the next RUN.
  - The d-accumulator is internal; the output d is a separate register.
- Latency: start accepted at edge E0 → done high during the cycle following edge E0+NIBBLES (16-bit: 4 edges after acceptance). Throughput is one operation per NIBBLES+1 cycles.
- Arithmetic: unsigned modulo 2^WIDTH. bout = 1 iff x < y + bin as unbounded integers. Inputs x/y/bin may change freely after acceptance.
- Boundary cases:
  - x == y with bin = 0 → d = 0, zero = 1, bout = 0.
  - x = y = 0 with bin = 1 → d = all-ones, bout = 1.
  - start held high continuously → a new operation starts every NIBBLES+1 cycles, each accepted in DONE.

Decomposition:
- Shared package sub_ctrl_pkg holds:
  - state enum/localparams: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  - NIBBLE_W = 4;
  - a function computing the index width, clog2(NIBBLES).
- One sub-module, sub4_slice: combinational 4-bit borrow-lookahead subtractor with port order (d[3:0], bout, x[3:0], y[3:0], bin).
  - Instantiated once; its operands are muxed by the nibble index.
- The controller holds the FSM, index counter, borrow register, operand/accumulator registers and flag logic.

Test Plan:
- Reset then idle: rst_n low for 2 cycles → all outputs 0; no done for 10 idle cycles.
- Basic subtraction: x = 0x1234, y = 0x0123, bin = 0, start for 1 cycle → busy high for 4 cycles, then done pulse with d = 0x1111, bout = 0, zero = 0, ovf = 0.
- Borrow chain: x = 0x0005, y = 0x000D, bin = 0 → d = 0xFFF8, bout = 1. Then x = 0x0000, y = 0x0000, bin = 1 → d = 0xFFFF, bout = 1.
- Zero and overflow flags:
  - x = 0xC0DE, y = 0xC0DE, bin = 0 → d = 0x0000, zero = 1.
  - x = 0x8000, y = 0x0001, bin = 0 → d = 0x7FFF, ovf = 1, bout = 0.
- Start during busy:
  - Pulse start with x = 0x0001, y = 0x0001 in the second RUN cycle of a 0x1234 - 0x0123 operation → ignored; result still 0x1111; exactly one done.
  - Start held high → back-to-back results every 5 cycles.
- Reset mid-operation: rst_n low during the third RUN cycle → busy = 0 and d = 0 immediately, no done pulse. A subsequent 0x00FF - 0x000F operation gives d = 0x00F0.
